// File: rtl/ladybird_config.sv
// Shared types and helpers for the ladybird load/store unit.
// The bus data width is fixed at 32 bits.
package ladybird_config;

    localparam int XLEN = 32;

    // The encoding is {store, funct3}, so loads and stores that share a funct3
    // value still get distinct enum values.
    typedef enum logic [3:0] {
        LSU_LB  = 4'b0000,
        LSU_LH  = 4'b0001,
        LSU_LW  = 4'b0010,
        LSU_LBU = 4'b0100,
        LSU_LHU = 4'b0101,
        LSU_SB  = 4'b1000,
        LSU_SH  = 4'b1001,
        LSU_SW  = 4'b1010
    } lsu_funct3_t;

    typedef struct packed {
        logic [1:0] offset;
        logic [2:0] funct3;
        logic       store;
    } lsu_meta_t;

    typedef struct packed {
        logic            error;
        logic [XLEN-1:0] data;
    } lsu_resp_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic bad;
        bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        return bad || (funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off != 2'b00);
    endfunction

    function automatic logic [XLEN/8-1:0] store_strb(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [2:0] funct3, input logic [XLEN-1:0] data);
        case (funct3[1:0])
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] format_load(input logic [XLEN-1:0] rdata, input lsu_meta_t m);
        logic [XLEN-1:0] s;
        s = rdata >> {m.offset, 3'b000};
        case (lsu_funct3_t'({m.store, m.funct3}))
            LSU_LB:  return {{24{s[7]}}, s[7:0]};
            LSU_LH:  return {{16{s[15]}}, s[15:0]};
            LSU_LW:  return s;
            LSU_LBU: return {24'd0, s[7:0]};
            LSU_LHU: return {16'd0, s[15:0]};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/ladybird_fifo.sv
// Synchronous FIFO. The pointers carry one extra bit beyond the index width,
// which is how a full FIFO is told apart from an empty one.
module ladybird_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             anrst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    generate
        if (DEPTH == 1) begin : g_single
            assign wr_idx = '0;
            assign rd_idx = '0;
        end else begin : g_multi
            assign wr_idx = wr_ptr[IW-1:0];
            assign rd_idx = rd_ptr[IW-1:0];
        end
    endgenerate

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (PW'(wr_ptr - rd_ptr) == PW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_idx];

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= wdata;
    end

endmodule

// File: rtl/ladybird_lsu.sv
// Pipelined load/store unit: in-order bus transactions, byte lanes, load extension.
// Define LADYBIRD_LSU_PERF_CNT_EN to add the perf_loads/perf_stores/perf_stalls counters.
module ladybird_lsu
    import ladybird_config::*;
#(
    parameter int XLEN  = ladybird_config::XLEN,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              anrst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_data,
    input  logic [2:0]        i_funct3,
    input  logic              i_store,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [XLEN-1:0]   o_data,
    output logic              o_error,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_wstrb,
    input  logic              bus_data_gnt,
    input  logic [XLEN-1:0]   bus_rdata
`ifdef LADYBIRD_LSU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_loads,
    output logic [31:0]       perf_stores,
    output logic [31:0]       perf_stalls
`endif
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count;
    logic          full;
    logic          misaligned;
    logic          mis_accept;
    logic          bus_accept;
    logic          accept;
    logic          pop;
    logic          meta_pop;
    logic          resp_push;
    logic          meta_full;
    logic          meta_empty;
    logic          resp_full;
    logic          resp_empty;
    lsu_meta_t     meta_in;
    lsu_meta_t     meta_head;
    lsu_resp_t     resp_in;
    lsu_resp_t     resp_head;

    assign misaligned = is_misaligned(i_funct3, i_addr[1:0]);
    assign full       = (count == CW'(DEPTH));

    // The reset term keeps bus_req and i_ready low while anrst is asserted.
    assign bus_req    = anrst & i_valid & ~misaligned & ~full & ~meta_full;
    assign bus_accept = bus_req & bus_gnt;
    // A faulting op only goes straight to the response queue once the bus has
    // drained, so its response cannot overtake an older bus response.
    assign mis_accept = anrst & i_valid & misaligned & meta_empty & ~full & ~resp_full;
    assign i_ready    = bus_accept | mis_accept;
    assign accept     = i_valid & i_ready;

    assign bus_addr   = {i_addr[XLEN-1:2], 2'b00};
    assign bus_wdata  = store_data(i_funct3, i_data);
    assign bus_wstrb  = i_store ? store_strb(i_funct3, i_addr[1:0]) : '0;

    assign meta_pop   = bus_data_gnt & ~meta_empty;
    assign resp_push  = meta_pop | mis_accept;
    assign pop        = ~resp_empty & o_ready;

    always_comb begin
        meta_in        = '0;
        meta_in.offset = i_addr[1:0];
        meta_in.funct3 = i_funct3;
        meta_in.store  = i_store;
    end

    always_comb begin
        resp_in = '0;
        if (mis_accept) begin
            resp_in.error = 1'b1;
            resp_in.data  = i_addr;
        end else begin
            resp_in.data  = format_load(bus_rdata, meta_head);
        end
    end

    ladybird_fifo #(.WIDTH($bits(lsu_meta_t)), .DEPTH(DEPTH)) u_meta_fifo (
        .clk   (clk),
        .anrst (anrst),
        .push  (bus_accept),
        .wdata (meta_in),
        .pop   (meta_pop),
        .rdata (meta_head),
        .full  (meta_full),
        .empty (meta_empty)
    );

    ladybird_fifo #(.WIDTH($bits(lsu_resp_t)), .DEPTH(DEPTH)) u_resp_fifo (
        .clk   (clk),
        .anrst (anrst),
        .push  (resp_push),
        .wdata (resp_in),
        .pop   (pop),
        .rdata (resp_head),
        .full  (resp_full),
        .empty (resp_empty)
    );

    assign o_valid = ~resp_empty;
    assign o_data  = resp_empty ? '0 : resp_head.data;
    assign o_error = ~resp_empty & resp_head.error;

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            count <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef LADYBIRD_LSU_PERF_CNT_EN
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            perf_loads  <= '0;
            perf_stores <= '0;
            perf_stalls <= '0;
        end else begin
            if (bus_accept && !i_store) perf_loads  <= perf_loads + 32'd1;
            if (bus_accept && i_store)  perf_stores <= perf_stores + 32'd1;
            if (i_valid && !i_ready)    perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

`ifdef SIMULATION
    always @(posedge clk) begin
        if (anrst && bus_data_gnt) begin
            assert (!meta_empty) else $error("ladybird_lsu: bus_data_gnt with no outstanding request");
        end
    end
`endif

endmodule
